// File: rtl/fft_cmul_round_sat.sv
// Complex twiddle-product combiner: sums the four DSP partial products, rounds half-to-even,
// saturates to OUT_W and streams out with full backpressure plus overflow statistics.
module fft_cmul_round_sat_rnd #(
  parameter int PROD_W = 41,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 24
) (
  input  logic signed [PROD_W:0]  i_s,
  output logic signed [OUT_W-1:0] o_q,
  output logic                    o_sat
);
  // PROD_W+2-SHIFT bits hold floor(S/2^SHIFT)+1 without wrapping
  localparam int RW = PROD_W + 2 - SHIFT;
  localparam logic signed [RW-1:0] MAXV = RW'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [RW-1:0] MINV = -MAXV - RW'(1);

  logic signed [RW-1:0] w_t, w_r;
  logic [SHIFT-1:0]     w_f, w_half;
  logic                 w_up;

  always_comb begin
    w_t    = RW'(i_s >>> SHIFT);
    w_f    = i_s[SHIFT-1:0];
    w_half = '0;
    w_half[SHIFT-1] = 1'b1;
    w_up   = (w_f > w_half) || ((w_f == w_half) && w_t[0]);
    w_r    = w_t + RW'(w_up);
    o_q    = w_r[OUT_W-1:0];
    o_sat  = 1'b0;
    if (w_r > MAXV) begin
      o_q   = MAXV[OUT_W-1:0];
      o_sat = 1'b1;
    end else if (w_r < MINV) begin
      o_q   = MINV[OUT_W-1:0];
      o_sat = 1'b1;
    end
  end
endmodule

module fft_cmul_round_sat #(
  parameter int PROD_W = 41,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 24,
  parameter int CNT_W  = 16
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     s_last,
  input  logic signed [PROD_W-1:0] p_rr,
  input  logic signed [PROD_W-1:0] p_ii,
  input  logic signed [PROD_W-1:0] p_ri,
  input  logic signed [PROD_W-1:0] p_ir,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [OUT_W-1:0]  m_re,
  output logic signed [OUT_W-1:0]  m_im,
  output logic                     m_last,
  output logic                     m_ovf,
  output logic                     ovf_sticky,
  output logic [CNT_W-1:0]         ovf_count,
  input  logic                     ovf_clr
);
  localparam int NUM_LANES = 2;   // lane 0 = real, lane 1 = imaginary

  logic                                r_s1_v, r_s1_last;
  logic [NUM_LANES-1:0][PROD_W:0]      r_s;
  logic [NUM_LANES-1:0][OUT_W-1:0]     w_q;
  logic [NUM_LANES-1:0]                w_sat;
  logic                                w_ld1, w_ld2, w_ovf_nxt;

  assign w_ld2     = !m_valid || m_ready;
  assign w_ld1     = !r_s1_v || w_ld2;
  assign s_ready   = w_ld1;
  assign w_ovf_nxt = r_s1_v && (|w_sat);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    fft_cmul_round_sat_rnd #(.PROD_W(PROD_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_rnd (
      .i_s   (r_s[g]),
      .o_q   (w_q[g]),
      .o_sat (w_sat[g])
    );
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_s1_v    <= 1'b0;
      r_s1_last <= 1'b0;
      r_s       <= '0;
    end else if (w_ld1) begin
      r_s1_v    <= s_valid;
      r_s1_last <= s_last;
      r_s[0]    <= {p_rr[PROD_W-1], p_rr} - {p_ii[PROD_W-1], p_ii};
      r_s[1]    <= {p_ri[PROD_W-1], p_ri} + {p_ir[PROD_W-1], p_ir};
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      m_valid <= 1'b0;
      m_re    <= '0;
      m_im    <= '0;
      m_last  <= 1'b0;
      m_ovf   <= 1'b0;
    end else if (w_ld2) begin
      m_valid <= r_s1_v;
      m_re    <= w_q[0];
      m_im    <= w_q[1];
      m_last  <= r_s1_last;
      m_ovf   <= w_ovf_nxt;
    end
  end

  // clear wins over a coincident overflow event
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (w_ld2 && w_ovf_nxt) begin
      ovf_sticky <= 1'b1;
      if (ovf_count != '1) ovf_count <= ovf_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_fft_cmul_round_sat.sv
// Directed scoreboard bench for fft_cmul_round_sat: rounding, saturation, backpressure,
// counter saturation/clear, async reset and full throughput.
module tb_fft_cmul_round_sat;
  localparam int PW = 41, OW = 16, CW = 16;

  typedef struct packed {
    logic signed [OW-1:0] re;
    logic signed [OW-1:0] im;
    logic                 last;
    logic                 ovf;
  } exp_t;

  logic                 ap_clk = 1'b0, ap_rst_n;
  logic                 s_valid, s_ready, s_last, m_valid, m_ready, m_last, m_ovf;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [OW-1:0] m_re, m_im;
  logic                 ovf_sticky, ovf_clr;
  logic [CW-1:0]        ovf_count;

  exp_t q[$];
  exp_t cur, e;
  int   nchk = 0, nerr = 0;
  bit   rnd_rdy = 1'b0;
  logic stall_d = 1'b0;
  logic [2*OW+1:0] prev;

  fft_cmul_round_sat #(.PROD_W(PW), .OUT_W(OW), .SHIFT(24), .CNT_W(CW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .p_rr(p_rr), .p_ii(p_ii), .p_ri(p_ri), .p_ir(p_ir),
    .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im),
    .m_last(m_last), .m_ovf(m_ovf),
    .ovf_sticky(ovf_sticky), .ovf_count(ovf_count), .ovf_clr(ovf_clr)
  );

  always #5 ap_clk = ~ap_clk;

  // value in half-units of 2^24
  function automatic logic signed [PW-1:0] h(input longint halves);
    return PW'(halves * 64'sd8388608);
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on acceptance, pop on transfer, checked away from the active edge
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      q.delete();
      stall_d = 1'b0;
    end else begin
      chk("s_ready", s_ready, !(q.size() >= 2 && !m_ready));
      if (stall_d) chk("stall_hold", {m_valid, m_re, m_im, m_last, m_ovf}, {1'b1, prev});
      if (m_valid && m_ready) begin
        if (q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = q.pop_front();
          chk("m_re", m_re, e.re);
          chk("m_im", m_im, e.im);
          chk("m_last", m_last, e.last);
          chk("m_ovf", m_ovf, e.ovf);
        end
      end
      if (s_valid && s_ready) q.push_back(cur);
      stall_d = m_valid && !m_ready;
      prev    = {m_re, m_im, m_last, m_ovf};
    end
  end

  task automatic send(input logic signed [PW-1:0] rr, ii, ri, ir, input logic last,
                      input logic signed [OW-1:0] ere, eim, input logic eovf);
    bit acc = 1'b0;
    cur = '{ere, eim, last, eovf};
    p_rr = rr; p_ii = ii; p_ri = ri; p_ir = ir;
    s_last = last; s_valid = 1'b1;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge ap_clk);
      acc = s_ready;
      @(posedge ap_clk); #1;
      if (rnd_rdy) m_ready = 1'($urandom_range(0, 1));
    end
    s_valid = 1'b0; s_last = 1'b0;
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && q.size() != 0; k++) begin
      @(posedge ap_clk); #1;
      m_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    chk("drain", q.size(), 0);
    m_ready = 1'b1;
  endtask

  initial begin
    ap_rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1; ovf_clr = 1'b0;
    p_rr = '0; p_ii = '0; p_ri = '0; p_ir = '0; cur = '0;
    repeat (2) @(posedge ap_clk);
    #1;
    chk("rst_out", {m_valid, m_re, m_im, m_last, m_ovf}, 0);
    chk("rst_stat", {ovf_sticky, ovf_count}, 0);
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    // rounding + two-cycle latency
    send(h(7), 0, 0, 0, 0, 4, 0, 0);
    chk("lat_c1", m_valid, 0);
    @(posedge ap_clk); #1;
    chk("lat_c2", m_valid, 1);
    send(h(5), 0, 0, 0, 0, 2, 0, 0);
    send(h(-5), 0, 0, 0, 0, -2, 0, 0);
    send(h(5) + 41'sd1, 0, 0, 0, 0, 3, 0, 0);
    send(h(-7), 0, 0, 0, 0, -4, 0, 0);
    send(h(1), 0, 0, 0, 0, 0, 0, 0);
    send(h(20), h(6), h(4), h(2), 0, 7, 3, 0);
    send(0, 0, h(40000), h(40000), 0, 0, 32767, 1);
    drain();
    chk("cnt_1", ovf_count, 1);
    chk("sticky_1", ovf_sticky, 1);
    send(0, h(80000), 0, 0, 0, -32768, 0, 1);
    send(h(65535), 0, 0, 0, 0, 32767, 0, 1);
    send(h(-65537), 0, 0, 0, 0, -32768, 0, 0);
    drain();
    chk("cnt_3", ovf_count, 3);

    // backpressure with random downstream ready
    rnd_rdy = 1'b1;
    for (int i = 1; i <= 8; i++) send(h(2 * i), 0, 0, 0, (i == 8), OW'(i), 0, 0);
    drain();
    rnd_rdy = 1'b0;

    // counter saturation
    cur = '{0, 32767, 0, 1};
    p_rr = 0; p_ii = 0; p_ri = h(40000); p_ir = h(40000); s_valid = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      @(posedge ap_clk); #1;
    end
    s_valid = 1'b0;
    drain();
    chk("cnt_sat", ovf_count, 65535);
    chk("sticky_sat", ovf_sticky, 1);

    // clear coinciding with a saturating stage-2 load
    send(0, 0, h(40000), h(40000), 0, 0, 32767, 1);
    ovf_clr = 1'b1;
    @(posedge ap_clk); #1;
    ovf_clr = 1'b0;
    chk("clr_cnt", ovf_count, 0);
    chk("clr_sticky", ovf_sticky, 0);
    drain();

    // async reset with both stages full
    m_ready = 1'b0;
    send(0, 0, h(40000), h(40000), 0, 0, 32767, 1);
    send(0, 0, h(40000), h(40000), 0, 0, 32767, 1);
    chk("full_v", m_valid, 1);
    chk("full_rdy", s_ready, 0);
    chk("full_cnt", ovf_count, 1);
    ap_rst_n = 1'b0;
    #1;
    chk("arst_v", m_valid, 0);
    chk("arst_cnt", ovf_count, 0);
    chk("arst_re_im", {m_re, m_im}, 0);
    @(negedge ap_clk);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1; m_ready = 1'b1;
    send(h(14), 0, 0, 0, 1, 7, 0, 0);
    chk("rlat_c1", m_valid, 0);
    @(posedge ap_clk); #1;
    chk("rlat_c2", m_valid, 1);
    drain();

    // full throughput
    for (int k = 0; k < 100; k++) begin
      cur = '{OW'(k), 0, 0, 0};
      p_rr = h(2 * k); p_ii = 0; p_ri = 0; p_ir = 0; s_valid = 1'b1;
      @(negedge ap_clk);
      chk("tput_rdy", s_ready, 1);
      @(posedge ap_clk); #1;
      chk("tput_v", m_valid, (k >= 1));
    end
    s_valid = 1'b0;
    @(posedge ap_clk); #1;
    chk("tput_tail", m_valid, 1);
    @(posedge ap_clk); #1;
    chk("tput_end", m_valid, 0);
    chk("tput_q", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
